mem_access_sequencer: RTL and testbench

- Sequences every memory transaction the SPARC control unit requests through MOV/RW/SIZE/SU; sits between the control unit/MAR/MDR and the synchronous data RAM.
- Checks alignment, drives RAM enable/byte lanes for a fixed number of wait states, then returns MOC to the control unit.
- Performs big-endian lane steering with sign/zero extension on loads.
- Reports misaligned or illegal-size requests on Align_Err so the control unit can enter the trap sequence.

---
 rtl/mem_access_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Runs every memory transaction requested by the control unit (MOV/RW/SIZE/SU)
// against a synchronous data RAM: alignment check, fixed wait-state access,
// big-endian lane steering and load extension, then a MOC or Align_Err pulse.
//
// Ports
//   Clock, Reset         rising-edge clock, asynchronous active-low reset
//   MOV, RW, SIZE, SU    request handshake and attributes from the control unit
//   Address, DataIn      byte address (MAR) and right-justified store data (MDR)
//   DataOut              extended load data to MDR, held until the next load
//   MOC, Align_Err       one-cycle completion / misalignment pulses
//   Busy                 high whenever the sequencer is not idle
//   Ram_En, Ram_WE       RAM enable and write enable
//   Ram_Addr, Ram_BE     word address and big-endian byte enables
//   Ram_WData, Ram_RData lane-replicated store data, RAM read data
module mem_access_sequencer #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        SIZE,
    input  logic              SU,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              Align_Err,
    output logic              Busy,
    output logic              Ram_En,
    output logic              Ram_WE,
    output logic [ADDR_W-1:0] Ram_Addr,
    output logic [3:0]        Ram_BE,
    output logic [31:0]       Ram_WData,
    input  logic [31:0]       Ram_RData
);

    localparam int unsigned    CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_ERR,
        S_HOLD
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             accept;
    logic             load_cap;
    logic             req_bad;
    logic [3:0]       new_be;
    logic [31:0]      new_wdata;
    logic             rw_d;
    logic [3:0]       be_d;

    // Latched request attributes (valid from acceptance until the next one)
    logic             lat_rw;
    logic [1:0]       lat_size;
    logic [1:0]       lat_off;
    logic             lat_su;
    logic [3:0]       be_q;

    // Select the addressed byte/halfword from a big-endian word and extend it
    function automatic logic [31:0] extend_load(
        input logic [31:0] rdata,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        su
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = rdata[31:24];
            2'd1:    b = rdata[23:16];
            2'd2:    b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = off[1] ? rdata[15:0] : rdata[31:16];
        case (size)
            SZ_BYTE: res = {{24{su & b[7]}}, b};
            SZ_HALF: res = {{16{su & h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Request decode on the live inputs (only used at acceptance)
    always_comb begin
        req_bad   = 1'b0;
        new_be    = 4'b0000;
        new_wdata = DataIn;
        case (SIZE)
            SZ_BYTE: begin
                new_be    = 4'b1000 >> Address[1:0];
                new_wdata = {4{DataIn[7:0]}};
            end
            SZ_HALF: begin
                req_bad   = Address[0];
                new_be    = Address[1] ? 4'b0011 : 4'b1100;
                new_wdata = {2{DataIn[15:0]}};
            end
            SZ_WORD: begin
                req_bad   = (Address[1:0] != 2'b00);
                new_be    = 4'b1111;
                new_wdata = DataIn;
            end
            default: begin
                req_bad   = 1'b1;
                new_be    = 4'b0000;
                new_wdata = DataIn;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        accept   = 1'b0;
        load_cap = 1'b0;
        case (state)
            S_IDLE: begin
                if (MOV) begin
                    accept = 1'b1;
                    if (req_bad) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt == '0) begin
                    state_d  = S_DONE;
                    load_cap = lat_rw;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_DONE, S_ERR: begin
                state_d = MOV ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // RAM controls are registered from the next state, so the values being
    // latched this edge are the ones steering the first access cycle
    always_comb begin
        rw_d = accept ? RW     : lat_rw;
        be_d = accept ? new_be : be_q;
    end

    // State, request latch and registered outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_rw    <= 1'b0;
            lat_size  <= 2'b00;
            lat_off   <= 2'b00;
            lat_su    <= 1'b0;
            be_q      <= 4'b0000;
            DataOut   <= '0;
            MOC       <= 1'b0;
            Align_Err <= 1'b0;
            Busy      <= 1'b0;
            Ram_En    <= 1'b0;
            Ram_WE    <= 1'b0;
            Ram_Addr  <= '0;
            Ram_BE    <= 4'b0000;
            Ram_WData <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                lat_rw    <= RW;
                lat_size  <= SIZE;
                lat_off   <= Address[1:0];
                lat_su    <= SU;
                be_q      <= new_be;
                Ram_Addr  <= {Address[ADDR_W-1:2], 2'b00};
                Ram_WData <= new_wdata;
            end
            if (load_cap) begin
                DataOut <= extend_load(Ram_RData, lat_size, lat_off, lat_su);
            end
            Ram_En    <= (state_d == S_ACCESS);
            Ram_WE    <= (state_d == S_ACCESS) && !rw_d;
            Ram_BE    <= (state_d == S_ACCESS) ? be_d : 4'b0000;
            MOC       <= (state_d == S_DONE);
            Align_Err <= (state_d == S_ERR);
            Busy      <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed scenarios followed by
// randomized requests, checked against a byte-array memory model.
module tb_mem_access_sequencer;

    localparam int unsigned W  = 2;
    localparam int unsigned AW = 32;

    logic          Clock;
    logic          Reset;
    logic          MOV;
    logic          RW;
    logic [1:0]    SIZE;
    logic          SU;
    logic [AW-1:0] Address;
    logic [31:0]   DataIn;
    logic [31:0]   DataOut;
    logic          MOC;
    logic          Align_Err;
    logic          Busy;
    logic          Ram_En;
    logic          Ram_WE;
    logic [AW-1:0] Ram_Addr;
    logic [3:0]    Ram_BE;
    logic [31:0]   Ram_WData;
    logic [31:0]   Ram_RData;

    mem_access_sequencer #(
        .WAIT_CYCLES(W),
        .ADDR_W     (AW)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .MOV      (MOV),
        .RW       (RW),
        .SIZE     (SIZE),
        .SU       (SU),
        .Address  (Address),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .MOC      (MOC),
        .Align_Err(Align_Err),
        .Busy     (Busy),
        .Ram_En   (Ram_En),
        .Ram_WE   (Ram_WE),
        .Ram_Addr (Ram_Addr),
        .Ram_BE   (Ram_BE),
        .Ram_WData(Ram_WData),
        .Ram_RData(Ram_RData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Initial RAM image: word 0x10 holds 0x80F17F02, the rest a simple pattern
    function automatic logic [7:0] init_byte(input logic [7:0] a);
        logic [31:0] w;
        w = 32'h80F17F02;
        if (a[7:2] == 6'h04) return w[8*(3-int'(a[1:0])) +: 8];
        return 8'(int'(a) * 29 + 7);
    endfunction

    // RAM seen by the DUT (256 bytes, big-endian lanes)
    bit [7:0] ram_b [256];
    bit       ram_v [256];
    logic [7:0] rd_a;

    always_comb begin
        Ram_RData = '0;
        rd_a      = '0;
        for (int i = 0; i < 4; i++) begin
            rd_a      = {Ram_Addr[7:2], 2'(i)};
            Ram_RData = Ram_RData | (32'(ram_v[rd_a] ? ram_b[rd_a] : init_byte(rd_a)) << (8 * (3 - i)));
        end
    end

    always @(posedge Clock) begin
        if (Ram_En && Ram_WE) begin
            for (int i = 0; i < 4; i++) begin
                if (Ram_BE[3-i]) begin
                    ram_b[{Ram_Addr[7:2], 2'(i)}] <= Ram_WData[8*(3-i) +: 8];
                    ram_v[{Ram_Addr[7:2], 2'(i)}] <= 1'b1;
                end
            end
        end
    end

    function automatic logic [31:0] tb_word(input logic [7:0] a);
        logic [31:0] w;
        logic [7:0]  x;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            x = {a[7:2], 2'(i)};
            w = (w << 8) | 32'(ram_v[x] ? ram_b[x] : init_byte(x));
        end
        return w;
    endfunction

    // Bus monitor, sampled on the falling edge
    int          n_en = 0, n_we = 0, n_moc = 0, n_err = 0, n_bad = 0;
    int          last_en_cyc = 0, last_moc_cyc = 0, last_err_cyc = 0;
    logic [3:0]  be_at_en = '0;
    logic [31:0] wd_at_en = '0;
    logic [31:0] addr_at_en = '0;
    logic [31:0] dout_at_moc = '0;

    always @(negedge Clock) begin
        if (Ram_En) begin
            n_en++;
            last_en_cyc = cyc;
            be_at_en    = Ram_BE;
            wd_at_en    = Ram_WData;
            addr_at_en  = Ram_Addr;
        end
        if (Ram_WE) n_we++;
        if (!Ram_En && (Ram_WE || Ram_BE != 4'b0000)) n_bad++;
        if (MOC) begin
            n_moc++;
            last_moc_cyc = cyc;
            dout_at_moc  = DataOut;
        end
        if (Align_Err) begin
            n_err++;
            last_err_cyc = cyc;
        end
    end

    // Reference model: plain byte-addressed memory plus last loaded value
    logic [7:0]  ref_mem [256];
    logic [31:0] exp_dout;
    int          n_cmp = 0;
    int          n_mis = 0;

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w = (w << 8) | 32'(ref_mem[{a[7:2], 2'(i)}]);
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] a, input int n, input logic su);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[8'(int'(a) + i)]);
        if (su && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    // One complete request: drive, wait for MOC/Align_Err, optional hold or
    // early MOV drop, release, then compare bus activity and data to the model
    task automatic txn(input logic [31:0] addr, input logic rw, input logic [1:0] size,
                       input logic su, input logic [31:0] din, input int hold, input bit drop);
        int          n, c0, en0, we0, moc0, err0, bad0, m;
        bit          legal, seen;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld;
        logic [7:0]  a8;
        n     = 1 << size;
        a8    = addr[7:0];
        legal = (size != 2'b11) && ((int'(addr[1:0]) % n) == 0);
        tick();
        c0 = cyc; en0 = n_en; we0 = n_we; moc0 = n_moc; err0 = n_err; bad0 = n_bad;
        Address = addr; RW = rw; SIZE = size; SU = su; DataIn = din; MOV = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (i == 0) begin
                Address = $urandom; RW = 1'($urandom); SIZE = 2'($urandom);
                SU = 1'($urandom); DataIn = $urandom;
                if (drop) MOV = 1'b0;
            end
            if (MOC || Align_Err) seen = 1'b1;
        end
        check("response_seen", 32'(seen), 32'd1);
        if (drop) begin
            tick();
            check("idle_after_drop", 32'(Busy), 32'd0);
        end
        for (int h = 0; h < hold; h++) tick();
        if (hold > 0) check("busy_in_hold", 32'(Busy), 32'd1);
        MOV = 1'b0;
        for (int i = 0; i < 10 && Busy; i++) tick();
        check("busy_release", 32'(Busy), 32'd0);
        tick();
        tick();
        if (legal) begin
            ebe = '0;
            for (int i = 0; i < n; i++) ebe[3 - (int'(addr[1:0]) + i)] = 1'b1;
            ewd = '0;
            for (int j = 0; j < 4; j++) begin
                m = j % n;
                ewd[8*(3-j) +: 8] = 8'(din >> (8 * (n - 1 - m)));
            end
            check("moc_count", 32'(n_moc - moc0), 32'd1);
            check("moc_cycle", 32'(last_moc_cyc), 32'(c0 + 1 + int'(W)));
            check("en_count", 32'(n_en - en0), 32'(W));
            check("en_last_cycle", 32'(last_en_cyc), 32'(c0 + int'(W)));
            check("we_count", 32'(n_we - we0), rw ? 32'd0 : 32'(W));
            check("err_count", 32'(n_err - err0), 32'd0);
            check("ram_be", 32'(be_at_en), 32'(ebe));
            check("ram_addr", addr_at_en, addr & ~32'd3);
            if (rw) begin
                eld      = ref_load(a8, n, su);
                exp_dout = eld;
                check("load_at_moc", dout_at_moc, eld);
            end else begin
                check("ram_wdata", wd_at_en, ewd);
                for (int i = 0; i < n; i++)
                    ref_mem[8'(int'(a8) + i)] = 8'(din >> (8 * (n - 1 - i)));
                check("mem_word", tb_word(a8), ref_word(a8));
            end
        end else begin
            check("err_count", 32'(n_err - err0), 32'd1);
            check("err_cycle", 32'(last_err_cyc), 32'(c0 + 1));
            check("err_no_en", 32'(n_en - en0), 32'd0);
            check("err_no_we", 32'(n_we - we0), 32'd0);
            check("err_no_moc", 32'(n_moc - moc0), 32'd0);
        end
        check("lanes_idle_outside_access", 32'(n_bad - bad0), 32'd0);
        check("dataout", DataOut, exp_dout);
    endtask

    int          moc_s;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    bit          r_drop;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(8'(i));
        exp_dout = '0;
        Reset = 1'b0; MOV = 1'b0; RW = 1'b0; SIZE = 2'b00; SU = 1'b0;
        Address = '0; DataIn = '0;
        repeat (3) tick();

        // Reset state
        check("rst_dataout", DataOut, 32'd0);
        check("rst_moc", 32'(MOC), 32'd0);
        check("rst_align_err", 32'(Align_Err), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_ram_en", 32'(Ram_En), 32'd0);
        check("rst_ram_we", 32'(Ram_WE), 32'd0);
        check("rst_ram_be", 32'(Ram_BE), 32'd0);
        check("rst_ram_addr", Ram_Addr, 32'd0);
        check("rst_ram_wdata", Ram_WData, 32'd0);
        Reset = 1'b1;
        repeat (2) tick();

        // Word and sub-word loads around 0x10
        txn(32'h10, 1'b1, 2'b10, 1'b0, 32'h0, 0, 1'b0);
        check("word_load", DataOut, 32'h80F17F02);
        txn(32'h11, 1'b1, 2'b00, 1'b1, 32'h0, 0, 1'b0);
        check("byte_load_signed", DataOut, 32'hFFFFFFF1);
        txn(32'h11, 1'b1, 2'b00, 1'b0, 32'h0, 0, 1'b0);
        check("byte_load_unsigned", DataOut, 32'h000000F1);
        txn(32'h10, 1'b1, 2'b01, 1'b1, 32'h0, 0, 1'b0);
        check("half_load_hi_signed", DataOut, 32'hFFFF80F1);
        txn(32'h12, 1'b1, 2'b01, 1'b1, 32'h0, 0, 1'b0);
        check("half_load_lo_signed", DataOut, 32'h00007F02);

        // Stores
        txn(32'h12, 1'b0, 2'b01, 1'b0, 32'h0000ABCD, 0, 1'b0);
        check("half_store_be", 32'(be_at_en), 32'h3);
        check("half_store_wdata", wd_at_en, 32'hABCDABCD);
        check("half_store_addr", addr_at_en, 32'h10);
        txn(32'h13, 1'b0, 2'b00, 1'b0, 32'h0000005A, 0, 1'b0);
        check("byte_store_be", 32'(be_at_en), 32'h1);
        check("byte_store_wdata", wd_at_en, 32'h5A5A5A5A);

        // Misaligned and illegal-size requests
        txn(32'h13, 1'b1, 2'b10, 1'b1, 32'h0, 0, 1'b0);
        txn(32'h11, 1'b0, 2'b01, 1'b0, 32'h1234, 0, 1'b0);
        txn(32'h10, 1'b1, 2'b11, 1'b0, 32'h0, 0, 1'b0);

        // Handshake: long hold after MOC, then MOV dropped mid-access
        txn(32'h10, 1'b1, 2'b10, 1'b0, 32'h0, 5, 1'b0);
        txn(32'h14, 1'b0, 2'b10, 1'b0, 32'hCAFEF00D, 0, 1'b1);
        txn(32'h14, 1'b1, 2'b10, 1'b0, 32'h0, 0, 1'b0);

        // Reset during the first access cycle of a store
        tick();
        moc_s   = n_moc;
        Address = 32'h20; RW = 1'b0; SIZE = 2'b10; SU = 1'b0; DataIn = 32'hDEADBEEF; MOV = 1'b1;
        tick();
        check("rst_mid_pre_en", 32'(Ram_En), 32'd1);
        Reset = 1'b0;
        MOV   = 1'b0;
        #1;
        check("rst_mid_en", 32'(Ram_En), 32'd0);
        check("rst_mid_we", 32'(Ram_WE), 32'd0);
        check("rst_mid_dataout", DataOut, 32'd0);
        check("rst_mid_busy", 32'(Busy), 32'd0);
        exp_dout = '0;
        repeat (2) tick();
        Reset = 1'b1;
        repeat (4) tick();
        check("rst_mid_no_moc", 32'(n_moc - moc_s), 32'd0);
        check("rst_mid_mem", tb_word(8'h20), ref_word(8'h20));
        txn(32'h20, 1'b1, 2'b10, 1'b0, 32'h0, 0, 1'b0);

        // Randomized requests
        for (int k = 0; k < 40; k++) begin
            r_addr = {24'h0, 8'($urandom)};
            r_size = 2'($urandom_range(0, 3));
            if (r_size != 2'b11 && $urandom_range(0, 2) != 0)
                r_addr = r_addr & ~32'((1 << r_size) - 1);
            r_drop = ($urandom_range(0, 4) == 0);
            txn(r_addr, 1'($urandom), r_size, 1'($urandom), $urandom,
                r_drop ? 0 : int'($urandom_range(0, 3)), r_drop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
